// File: rtl/matrix_mult_mac_sched_pkg.sv
// Shared constants, FSM encoding and helpers for the DIM x DIM MAC-scheduled matrix multiplier.
package matrix_mult_pkg;

  localparam int DIM     = 4;
  localparam int DATA_W  = 8;
  localparam int PROD_W  = 2 * DATA_W;
  localparam int LOG_DIM = $clog2(DIM);
  localparam int ACC_W   = PROD_W + LOG_DIM;
  localparam int ADDR_W  = 2 * LOG_DIM;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/matrix_mult_mac_sched_if.sv
// Block-level handshake plus A/B read ports and C write port of the matrix multiplier.
interface matrix_mult_mac_sched_if;
  import matrix_mult_pkg::*;

  logic                      ap_start;
  logic                      ap_done;
  logic                      ap_idle;
  logic                      ap_ready;
  logic [ADDR_W-1:0]         A_address0;
  logic                      A_ce0;
  logic signed [DATA_W-1:0]  A_q0;
  logic [ADDR_W-1:0]         B_address0;
  logic                      B_ce0;
  logic signed [DATA_W-1:0]  B_q0;
  logic [ADDR_W-1:0]         C_address0;
  logic                      C_ce0;
  logic                      C_we0;
  logic signed [ACC_W-1:0]   C_d0;

  modport master (
    input  ap_start, A_q0, B_q0,
    output ap_done, ap_idle, ap_ready,
           A_address0, A_ce0, B_address0, B_ce0,
           C_address0, C_ce0, C_we0, C_d0
  );

  modport slave (
    output ap_start, A_q0, B_q0,
    input  ap_done, ap_idle, ap_ready,
           A_address0, A_ce0, B_address0, B_ce0,
           C_address0, C_ce0, C_we0, C_d0
  );

endinterface

// File: rtl/matrix_mult_mac_sched_mul.sv
// Combinational signed multiplier shared by every dot-product step.
module matrix_mult_mul_8s_8s_16_1_1 #(
  parameter int din0_WIDTH = 8,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 16
) (
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic signed [dout_WIDTH-1:0] dout
);

  assign dout = din0 * din1;

endmodule

// File: rtl/matrix_mult_mac_sched.sv
// Sequences C = A*B through one shared multiplier: issue (p1), multiply-accumulate (p2), C write.
module matrix_mult_mac_sched
  import matrix_mult_pkg::*;
(
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  matrix_mult_mac_sched_if.master bus
);

  state_t                  state, state_nxt;
  logic [LOG_DIM-1:0]      i_cnt, j_cnt, k_cnt;
  logic                    flush_cnt;
  logic                    issue, last_issue;

  logic                    vld_p1, first_p1, last_p1;
  logic [ADDR_W-1:0]       idx_p1;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_p2, acc_sum;
  logic                    wr_vld_p2;
  logic [ADDR_W-1:0]       wr_addr_p2;
  logic signed [ACC_W-1:0] wr_data_p2;

  assign issue      = (state == RUN);
  assign last_issue = issue && (&{i_cnt, j_cnt, k_cnt});

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.ap_start) state_nxt = RUN;
      RUN:     if (last_issue)   state_nxt = FLUSH;
      FLUSH:   if (flush_cnt)    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ap_idle    = (state == IDLE);
    bus.ap_done    = (state == DONE);
    bus.ap_ready   = (state == DONE);
    bus.A_ce0      = issue;
    bus.B_ce0      = issue;
    bus.A_address0 = issue ? {i_cnt, k_cnt} : '0;
    bus.B_address0 = issue ? {k_cnt, j_cnt} : '0;
  end

  // k runs fastest, then j, then i; all wrap back to zero after the final issue
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      i_cnt     <= '0;
      j_cnt     <= '0;
      k_cnt     <= '0;
      flush_cnt <= 1'b0;
    end else begin
      if (state == IDLE && bus.ap_start) begin
        i_cnt <= '0;
        j_cnt <= '0;
        k_cnt <= '0;
      end else if (issue) begin
        k_cnt <= k_cnt + 1'b1;
        if (&k_cnt) begin
          j_cnt <= j_cnt + 1'b1;
          if (&j_cnt) i_cnt <= i_cnt + 1'b1;
        end
      end
      flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;
    end
  end

  // p1: issue registered alongside the memory read latency
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
    end else begin
      vld_p1   <= issue;
      first_p1 <= (k_cnt == '0);
      last_p1  <= &k_cnt;
    end
  end

  always_ff @(posedge ap_clk) begin
    idx_p1 <= {i_cnt, j_cnt};
  end

  matrix_mult_mul_8s_8s_16_1_1 #(
    .din0_WIDTH (DATA_W),
    .din1_WIDTH (DATA_W),
    .dout_WIDTH (PROD_W)
  ) u_mul (
    .din0 (bus.A_q0),
    .din1 (bus.B_q0),
    .dout (prod)
  );

  // p2: accumulate; the final term of a dot product also launches its C write
  assign acc_sum = (first_p1 ? '0 : acc_p2) + sext_prod(prod);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc_p2    <= '0;
      wr_vld_p2 <= 1'b0;
    end else begin
      if (vld_p1) acc_p2 <= acc_sum;
      wr_vld_p2 <= vld_p1 && last_p1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (vld_p1 && last_p1) begin
      wr_addr_p2 <= idx_p1;
      wr_data_p2 <= acc_sum;
    end
  end

  assign bus.C_we0      = wr_vld_p2;
  assign bus.C_ce0      = wr_vld_p2;
  assign bus.C_address0 = wr_vld_p2 ? wr_addr_p2 : '0;
  assign bus.C_d0       = wr_vld_p2 ? wr_data_p2 : '0;

endmodule

// File: tb/tb_matrix_mult_mac_sched.sv
// Directed and random checks of the matrix multiplier: timing, handshake, results, reset abort.
module tb_matrix_mult_mac_sched;
  import matrix_mult_pkg::*;

  localparam int NEL    = DIM * DIM;
  localparam int NISS   = DIM * DIM * DIM;
  localparam int LASTC  = NISS + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  matrix_mult_mac_sched_if bus();

  matrix_mult_mac_sched dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic signed [DATA_W-1:0] a_mem [NEL];
  logic signed [DATA_W-1:0] b_mem [NEL];
  logic signed [ACC_W-1:0]  c_got [NEL];
  logic signed [ACC_W-1:0]  c_exp [NEL];

  int checks = 0;
  int errors = 0;

  always @(posedge clk) begin
    if (bus.A_ce0) bus.A_q0 <= a_mem[bus.A_address0];
    if (bus.B_ce0) bus.B_q0 <= b_mem[bus.B_address0];
  end

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void golden();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        int sum = 0;
        for (int k = 0; k < DIM; k++) sum += int'(a_mem[r*DIM+k]) * int'(b_mem[k*DIM+c]);
        c_exp[r*DIM+c] = ACC_W'(sum);
      end
  endfunction

  // Called at a negedge while the DUT is IDLE; returns at the negedge of cycle DIM^3+3 (IDLE).
  task automatic run_mat(input string tag, input bit hold, input bit pulse);
    int n_wr = 0, wr_bad = 0, iss_bad = 0, c_bad = 0;
    int done_cnt = 0, done_cyc = -1, idle_low = 0;
    logic idle_end = 1'b0;
    logic [ADDR_W-1:0] ea, eb;
    logic exp_ce;
    for (int n = 0; n < NEL; n++) c_got[n] = '1;
    bus.ap_start = 1'b1;
    for (int cyc = 0; cyc <= LASTC; cyc++) begin
      @(negedge clk);
      exp_ce = (cyc < NISS);
      ea = exp_ce ? ADDR_W'((cyc / NEL) * DIM + (cyc % DIM)) : '0;
      eb = exp_ce ? ADDR_W'((cyc % DIM) * DIM + ((cyc / DIM) % DIM)) : '0;
      if (bus.A_ce0 !== exp_ce || bus.B_ce0 !== exp_ce ||
          bus.A_address0 !== ea || bus.B_address0 !== eb) iss_bad++;
      if (bus.C_ce0 !== bus.C_we0) c_bad++;
      if (bus.C_we0 !== 1'b1 && (bus.C_address0 !== '0 || bus.C_d0 !== '0)) c_bad++;
      if (bus.ap_ready !== bus.ap_done) c_bad++;
      if (bus.C_we0 === 1'b1) begin
        if (n_wr >= NEL || bus.C_address0 !== ADDR_W'(n_wr) || cyc != n_wr * DIM + DIM + 1) wr_bad++;
        c_got[bus.C_address0] = bus.C_d0;
        n_wr++;
      end
      if (bus.ap_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.ap_idle !== 1'b1) idle_low++;
      if (cyc == LASTC) idle_end = bus.ap_idle;
      if (!hold) bus.ap_start = pulse && (cyc == 10 || cyc == 64);
    end
    check({tag, "/writes"},   n_wr,     NEL);
    check({tag, "/wr_order"}, wr_bad,   0);
    check({tag, "/issue"},    iss_bad,  0);
    check({tag, "/cport"},    c_bad,    0);
    check({tag, "/done_cnt"}, done_cnt, 1);
    check({tag, "/done_cyc"}, done_cyc, NISS + 2);
    check({tag, "/idle_low"}, idle_low, NISS + 3);
    check({tag, "/idle_end"}, 32'(idle_end), 1);
    for (int n = 0; n < NEL; n++)
      check($sformatf("%s/C%0d", tag, n), c_got[n], c_exp[n]);
  endtask

  task automatic load_identity();
    for (int n = 0; n < NEL; n++) begin
      a_mem[n]  = (n / DIM == n % DIM) ? 8'sd1 : 8'sd0;
      b_mem[n]  = DATA_W'(n + 1);
      c_exp[n]  = ACC_W'(n + 1);
    end
  endtask

  task automatic reset_mid(input string tag, input int at_cyc);
    int late_wr = 0, busy = 0;
    load_identity();
    bus.ap_start = 1'b1;
    @(negedge clk);
    bus.ap_start = 1'b0;
    repeat (at_cyc) @(negedge clk);
    rst = 1'b1;
    #1;
    check({tag, "/idle"}, 32'(bus.ap_idle), 1);
    check({tag, "/ce"},   32'({bus.A_ce0, bus.B_ce0, bus.C_ce0, bus.C_we0}), 0);
    check({tag, "/done"}, 32'(bus.ap_done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < NISS + 10; cyc++) begin
      @(negedge clk);
      if (bus.C_we0 !== 1'b0) late_wr++;
      if (bus.ap_idle !== 1'b1) busy++;
    end
    check({tag, "/late_wr"}, late_wr, 0);
    check({tag, "/stay_idle"}, busy, 0);
    run_mat({tag, "/rerun"}, 1'b0, 1'b0);
  endtask

  initial begin
    bus.ap_start = 1'b0;
    bus.A_q0 = '0;
    bus.B_q0 = '0;
    #1;
    check("rst/idle",  32'(bus.ap_idle), 1);
    check("rst/done",  32'({bus.ap_done, bus.ap_ready}), 0);
    check("rst/ce",    32'({bus.A_ce0, bus.B_ce0, bus.C_ce0, bus.C_we0}), 0);
    check("rst/addr",  32'({bus.A_address0, bus.B_address0, bus.C_address0}), 0);
    check("rst/cd",    bus.C_d0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    load_identity();
    run_mat("ident", 1'b0, 1'b0);

    for (int n = 0; n < NEL; n++) begin
      a_mem[n] = -8'sd128;
      b_mem[n] = -8'sd128;
      c_exp[n] = 18'sh10000;
    end
    run_mat("neg_neg", 1'b0, 1'b0);

    for (int n = 0; n < NEL; n++) begin
      b_mem[n] = 8'sd127;
      c_exp[n] = -18'sd65024;
    end
    run_mat("neg_pos", 1'b0, 1'b0);

    for (int r = 0; r < 100; r++) begin
      for (int n = 0; n < NEL; n++) begin
        a_mem[n] = DATA_W'($urandom);
        b_mem[n] = DATA_W'($urandom);
      end
      golden();
      run_mat($sformatf("rand%0d", r), 1'b0, 1'b0);
    end

    load_identity();
    run_mat("b2b0", 1'b1, 1'b0);
    for (int n = 0; n < NEL; n++) begin
      a_mem[n] = -8'sd128;
      b_mem[n] = -8'sd128;
      c_exp[n] = 18'sh10000;
    end
    run_mat("b2b1", 1'b1, 1'b0);
    bus.ap_start = 1'b0;
    @(negedge clk);

    reset_mid("rst30", 30);
    reset_mid("rst33", 33);

    load_identity();
    run_mat("pulse", 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
